// File: rtl/l2_mem_arbiter_pkg.sv
// Shared L2 word/strobe types and geometry used by the L2 memory arbiter.
package l2_mem_arbiter_pkg;

    localparam int L2DataWidth  = 512;
    localparam int L2NumWords   = 1024;
    localparam int L2ByteOffset = $clog2(L2DataWidth / 8);

    typedef logic [L2DataWidth-1:0]   axi_data_t;
    typedef logic [L2DataWidth/8-1:0] axi_strb_t;

endpackage

// File: rtl/l2_mem_rr_picker.sv
// Combinational round-robin picker: first set request at/after ptr, circular.
module l2_mem_rr_picker #(
    parameter int NumReq = 4,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] onehot,
    output logic [IdxW-1:0]   idx,
    output logic              vld
);

    logic [NumReq-1:0] rot;
    logic [IdxW-1:0]   ofs;
    logic [IdxW:0]     sum;

    always_comb begin
        // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
        rot = NumReq'({req, req} >> ptr);
        vld = |req;
        ofs = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (rot[i]) ofs = IdxW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, ofs};
        if (sum >= (IdxW+1)'(NumReq)) sum = sum - (IdxW+1)'(NumReq);
        idx    = sum[IdxW-1:0];
        onehot = vld ? (NumReq'(1) << idx) : '0;
    end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter with bounded burst-hold sharing one single-port L2 SRAM
// between several axi2mem requesters; routes the 1-cycle SRAM response back.
module l2_mem_arbiter
    import l2_mem_arbiter_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = L2DataWidth,
    parameter int NumWords   = L2NumWords,
    parameter int ByteOffset = L2ByteOffset,
    parameter int MaxBurst   = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NumReq-1:0]                       req_i,
    output logic [NumReq-1:0]                       gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]        addr_i,
    input  logic [NumReq-1:0]                       we_i,
    input  logic [NumReq-1:0][DataWidth-1:0]        wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]      strb_i,
    output logic [NumReq-1:0]                       rvalid_o,
    output logic [DataWidth-1:0]                    rdata_o,
    output logic                                    mem_req_o,
    output logic                                    mem_we_o,
    output logic [$clog2(NumWords)-1:0]             mem_addr_o,
    output logic [DataWidth-1:0]                    mem_wdata_o,
    output logic [DataWidth/8-1:0]                  mem_be_o,
    input  logic [DataWidth-1:0]                    mem_rdata_i
);

    localparam int AW   = $clog2(NumWords);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxBurst + 1);

    typedef logic [IdxW-1:0] arb_idx_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t MaxCnt = cnt_t'(MaxBurst);

    function automatic arb_idx_t wrap_inc(arb_idx_t i);
        return (i == arb_idx_t'(NumReq - 1)) ? '0 : i + 1'b1;
    endfunction

    arb_idx_t          ptr_q, owner_q, resp_idx_q;
    logic              owner_vld_q, resp_vld_q;
    cnt_t              cnt_q;

    logic              others, hold, any;
    arb_idx_t          arb_ptr, pick_idx, win, sel;
    logic [NumReq-1:0] pick_oh;
    logic              pick_vld;
    logic              unused_addr;

    // The owner keeps the port until it drops req or exhausts its burst while others wait.
    assign others  = |(req_i & ~(NumReq'(1) << owner_q));
    assign hold    = owner_vld_q && req_i[owner_q] && ((cnt_q < MaxCnt) || !others);
    assign arb_ptr = (owner_vld_q && !hold) ? wrap_inc(owner_q) : ptr_q;

    l2_mem_rr_picker #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_picker (
        .req    (req_i),
        .ptr    (arb_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

    assign win   = hold ? owner_q : pick_idx;
    assign any   = pick_vld && !rst_i;
    assign sel   = any ? win : '0;
    assign gnt_o = !any ? '0 : hold ? (NumReq'(1) << owner_q) : pick_oh;

    assign mem_req_o   = any;
    assign mem_we_o    = we_i[sel];
    assign mem_addr_o  = addr_i[sel][ByteOffset +: AW];
    assign mem_wdata_o = wdata_i[sel];
    assign mem_be_o    = strb_i[sel];
    assign unused_addr = ^addr_i;

    assign rvalid_o = (resp_vld_q && !rst_i) ? (NumReq'(1) << resp_idx_q) : '0;
    assign rdata_o  = mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            cnt_q       <= '0;
            resp_idx_q  <= '0;
            resp_vld_q  <= 1'b0;
        end else begin
            ptr_q      <= arb_ptr;
            resp_vld_q <= any;
            resp_idx_q <= win;
            if (hold) begin
                cnt_q <= (cnt_q < MaxCnt) ? cnt_q + 1'b1 : cnt_q;
            end else if (pick_vld) begin
                owner_q     <= pick_idx;
                owner_vld_q <= 1'b1;
                cnt_q       <= cnt_t'(1);
            end else begin
                owner_vld_q <= 1'b0;
                cnt_q       <= '0;
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(rvalid_o));
    a_gnt_req: assert property (@(posedge clk_i) disable iff (rst_i) (gnt_o & ~req_i) == '0);
    a_rvalid_gnt: assert property (@(posedge clk_i) disable iff (rst_i) |rvalid_o |-> $past(|gnt_o));

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Scoreboard bench: two arbiters (MaxBurst 1 and 4) with behavioural SRAMs;
// the driver queues expected grants/responses, a negedge monitor pops and compares.
module tb_l2_mem_arbiter;
    import l2_mem_arbiter_pkg::*;

    localparam int NR  = 4;
    localparam int AWD = 32;
    localparam int DW  = 512;
    localparam int SW  = 64;
    localparam int NW  = 1024;
    localparam int AW  = 10;

    typedef struct {
        int        idx;
        int        maddr;
        int        we;
        bit        chkd;
        axi_data_t data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]               rst;
    logic [NR-1:0]            req, we;
    logic [NR-1:0][AWD-1:0]   addr;
    logic [NR-1:0][DW-1:0]    wdata;
    logic [NR-1:0][SW-1:0]    strb;

    logic [NR-1:0] gnt [2];
    logic [NR-1:0] rvalid [2];
    axi_data_t     rdata [2];
    axi_data_t     mem_wdata [2];
    axi_strb_t     mem_be [2];
    logic          mem_req [2];
    logic          mem_we [2];
    logic [AW-1:0] mem_addr [2];
    logic [NR-1:0] prev_gnt [2];

    exp_t gq [2][$];
    exp_t rq [2][$];
    int   checks = 0;
    int   errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_data_t mrd;
        logic [DW-1:0] mem [NW];

        l2_mem_arbiter #(
            .NumReq   (NR),
            .AddrWidth(AWD),
            .DataWidth(DW),
            .NumWords (NW),
            .ByteOffset(6),
            .MaxBurst (g == 0 ? 1 : 4)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst[g]),
            .req_i      (req),
            .gnt_o      (gnt[g]),
            .addr_i     (addr),
            .we_i       (we),
            .wdata_i    (wdata),
            .strb_i     (strb),
            .rvalid_o   (rvalid[g]),
            .rdata_o    (rdata[g]),
            .mem_req_o  (mem_req[g]),
            .mem_we_o   (mem_we[g]),
            .mem_addr_o (mem_addr[g]),
            .mem_wdata_o(mem_wdata[g]),
            .mem_be_o   (mem_be[g]),
            .mem_rdata_i(mrd)
        );

        always @(posedge clk) begin
            if (mem_req[g]) begin
                if (mem_we[g])
                    for (int b = 0; b < SW; b++)
                        if (mem_be[g][b]) mem[mem_addr[g]][b*8 +: 8] <= mem_wdata[g][b*8 +: 8];
                mrd <= mem[mem_addr[g]];
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int d, input int idx, input bit resp = 1, input int maddr = -1,
                        input int wen = -1, input bit chkd = 0, input axi_data_t data = '0);
        exp_t e;
        e.idx = idx; e.maddr = maddr; e.we = wen; e.chkd = chkd; e.data = data;
        gq[d].push_back(e);
        if (resp) rq[d].push_back(e);
    endtask

    task automatic mon(input int d);
        exp_t e;
        logic [NR-1:0] oh;
        chk($sformatf("rvalid_lag%0d", d), rvalid[d], rst[d] ? '0 : prev_gnt[d]);
        chk($sformatf("mem_req%0d", d), mem_req[d], |gnt[d]);
        if (gnt[d] != '0) begin
            if (gq[d].size() == 0) chk($sformatf("gnt_unexpected%0d", d), gnt[d], '0);
            else begin
                e  = gq[d].pop_front();
                oh = NR'(1) << e.idx;
                chk($sformatf("gnt%0d", d), gnt[d], oh);
                if (e.maddr >= 0) chk("mem_addr", mem_addr[d], e.maddr);
                if (e.we >= 0) chk("mem_we", mem_we[d], e.we);
            end
        end
        if (rvalid[d] != '0) begin
            if (rq[d].size() == 0) chk($sformatf("rvalid_unexpected%0d", d), rvalid[d], '0);
            else begin
                e  = rq[d].pop_front();
                oh = NR'(1) << e.idx;
                chk($sformatf("rvalid%0d", d), rvalid[d], oh);
                if (e.chkd) chk("rdata", rdata[d], e.data);
            end
        end
        prev_gnt[d] = gnt[d];
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NR-1:0] r, input int n);
        req = r;
        repeat (n) cyc();
    endtask

    task automatic pulse();
        rst[1] = 1'b1;
        drive('0, 1);
        rst[1] = 1'b0;
    endtask

    initial begin
        rst = 2'b11; req = '0; we = '0; addr = '0; wdata = '0; strb = '0;
        prev_gnt[0] = '0; prev_gnt[1] = '0;

        // Reset with every requester asking: nothing may be granted.
        req = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_gnt0", gnt[0], '0);
            chk("rst_gnt1", gnt[1], '0);
            chk("rst_mem_req", mem_req[1], 1'b0);
            chk("rst_rvalid", rvalid[1], '0);
        end
        cyc();
        rst[1] = 1'b0;
        push(1, 0);
        drive(4'b1111, 1);
        drive('0, 2);

        // Burst-hold, MaxBurst=4: 0 x4, 2 x4, 0 x4.
        pulse();
        for (int i = 0; i < 12; i++) push(1, (i / 4 == 1) ? 2 : 0);
        drive(4'b0101, 12);
        drive('0, 2);

        // Sole requester runs past MaxBurst without a gap.
        pulse();
        repeat (10) push(1, 2);
        drive(4'b0100, 10);
        drive('0, 2);

        // Write by req1 then read by req3 of the same word.
        pulse();
        we[1] = 1'b1; addr[1] = 32'h8000_0040; wdata[1] = {64{8'hA5}}; strb[1] = '1;
        push(1, 1, 1, 1, 1);
        drive(4'b0010, 1);
        we[1] = 1'b0; addr[3] = 32'h8000_0040;
        push(1, 3, 1, 1, 0, 1, {64{8'hA5}});
        drive(4'b1000, 1);
        drive('0, 3);

        // Plain round-robin on the MaxBurst=1 instance.
        rst[1] = 1'b1;
        rst[0] = 1'b0;
        push(0, 0); push(0, 1); push(0, 2); push(0, 3); push(0, 0);
        drive(4'b1111, 5);
        drive('0, 2);
        rst[0] = 1'b1;

        // Reset mid-burst: pointer left at 3, grant to 0 in the cycle before reset.
        drive('0, 1);
        rst[1] = 1'b0;
        push(1, 2); push(1, 2);
        drive(4'b0100, 2);
        push(1, 0, 0);
        drive(4'b0001, 1);
        rst[1] = 1'b1;
        drive(4'b0001, 1);
        rst[1] = 1'b0;
        push(1, 0); push(1, 0); push(1, 0); push(1, 0); push(1, 1);
        drive(4'b1111, 5);
        drive('0, 2);

        chk("gq_left", gq[0].size() + gq[1].size(), '0);
        chk("rq_left", rq[0].size() + rq[1].size(), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
